mod_up_counter: RTL and testbench



---
 rtl/mod_up_counter.sv | 76 +++++++
 tb/tb_mod_up_counter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_up_counter.sv
// Modulo-MODULUS up counter with synchronous clamped load, a combinational
// terminal-count strobe for cascading, a one-shot halt mode and a saturating
// count of wrap events.
module mod_up_counter #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10,
    parameter int WRAPW   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             oneshot,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             done,
    output logic [WRAPW-1:0] wraps
);

    generate
        if (MODULUS < 2 || MODULUS > (2 ** WIDTH)) begin : g_bad_modulus
            $fatal(1, "mod_up_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
        end
    endgenerate

    localparam logic [WIDTH-1:0] TERM     = WIDTH'(MODULUS - 1);
    localparam logic [WRAPW-1:0] WRAP_MAX = {WRAPW{1'b1}};

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t           state;
    logic             at_term;
    logic [WIDTH-1:0] q_inc;
    logic [WIDTH-1:0] load_clamped;

    // Terminal compare, increment and load clamp for the next-state logic.
    // The increment is only used below TERM, so it can never carry out of
    // WIDTH bits, even when MODULUS == 2**WIDTH.
    always_comb begin
        at_term      = (q == TERM);
        q_inc        = q + WIDTH'(1);
        load_clamped = (load_val > TERM) ? TERM : load_val;
    end

    // Strobe is high only in the cycle whose edge will wrap or halt.
    assign tc   = (state == RUN) & en & ~load & at_term & ~reset;
    assign done = (state == HALT);

    // Count / load / halt state with reset > load > enable priority.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q     <= '0;
            state <= RUN;
            wraps <= '0;
        end else if (load) begin
            q     <= load_clamped;
            state <= RUN;
        end else if (state == RUN && en) begin
            if (!at_term) begin
                q <= q_inc;
            end else if (!oneshot) begin
                q <= '0;
                if (wraps != WRAP_MAX) begin
                    wraps <= wraps + WRAPW'(1);
                end
            end else begin
                state <= HALT;
            end
        end
    end

endmodule

// File: tb/tb_mod_up_counter.sv
// Self-checking bench for mod_up_counter: hand vectors, reference-model
// random stimulus, wrap saturation and two cascaded pairs (MODULUS 10 and 16).
module tb_mod_up_counter;

    localparam int M = 10;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_val = 4'd0;
    logic       oneshot = 1'b0;
    logic [3:0] q;
    logic       tc;
    logic       done;
    logic [7:0] wraps;

    logic       cen = 1'b0;
    logic [3:0] c1_q, c2_q, h1_q, h2_q;
    logic       c1_tc, c2_tc, h1_tc, h2_tc;
    logic       c1_done, c2_done, h1_done, h2_done;
    logic [7:0] c1_w, c2_w, h1_w, h2_w;

    int nchecks = 0;
    int nfail   = 0;

    // behavioural reference state
    int mq;
    int mw;
    bit mh;

    always #5 clk = ~clk;

    mod_up_counter #(.WIDTH(4), .MODULUS(10), .WRAPW(8)) u_dut (
        .clk(clk), .reset(reset), .en(en), .load(load), .load_val(load_val),
        .oneshot(oneshot), .q(q), .tc(tc), .done(done), .wraps(wraps));

    mod_up_counter #(.WIDTH(4), .MODULUS(10), .WRAPW(8)) u_c1 (
        .clk(clk), .reset(reset), .en(cen), .load(1'b0), .load_val(4'd0),
        .oneshot(1'b0), .q(c1_q), .tc(c1_tc), .done(c1_done), .wraps(c1_w));
    mod_up_counter #(.WIDTH(4), .MODULUS(10), .WRAPW(8)) u_c2 (
        .clk(clk), .reset(reset), .en(c1_tc), .load(1'b0), .load_val(4'd0),
        .oneshot(1'b0), .q(c2_q), .tc(c2_tc), .done(c2_done), .wraps(c2_w));

    mod_up_counter #(.WIDTH(4), .MODULUS(16), .WRAPW(8)) u_h1 (
        .clk(clk), .reset(reset), .en(cen), .load(1'b0), .load_val(4'd0),
        .oneshot(1'b0), .q(h1_q), .tc(h1_tc), .done(h1_done), .wraps(h1_w));
    mod_up_counter #(.WIDTH(4), .MODULUS(16), .WRAPW(8)) u_h2 (
        .clk(clk), .reset(reset), .en(h1_tc), .load(1'b0), .load_val(4'd0),
        .oneshot(1'b0), .q(h2_q), .tc(h2_tc), .done(h2_done), .wraps(h2_w));

    typedef struct {
        bit ld;
        int lv;
        bit en;
        bit os;
        int eq;
        bit etc;
        bit edone;
        int ew;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string nm, input logic [31:0] act, input int exp);
        nchecks++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        mq = 0;
        mw = 0;
        mh = 0;
    endtask

    function automatic bit model_tc(input bit l, input bit e);
        return !mh && e && !l && (mq == M - 1);
    endfunction

    task automatic model_step(input bit l, input int lv, input bit e, input bit o);
        if (l) begin
            mq = (lv > M - 1) ? M - 1 : lv;
            mh = 0;
        end else if (!mh && e) begin
            if (mq < M - 1) mq = mq + 1;
            else if (!o) begin
                mq = 0;
                mw = (mw + 1 > 255) ? 255 : mw + 1;
            end else mh = 1;
        end
    endtask

    // drive one cycle of inputs, check tc before the edge, state after it
    task automatic apply_check(input bit l, input int lv, input bit e, input bit o, input string nm);
        load     = l;
        load_val = lv[3:0];
        en       = e;
        oneshot  = o;
        #1;
        chk({nm, "_tc"}, tc, model_tc(l, e));
        tick();
        model_step(l, lv, e, o);
        chk({nm, "_q"}, q, mq);
        chk({nm, "_done"}, done, mh);
        chk({nm, "_wraps"}, wraps, mw);
    endtask

    task automatic do_reset();
        load = 0; en = 0; oneshot = 0; load_val = 0; cen = 0;
        @(posedge clk);
        #3;
        reset = 1;
        #1;
        chk("rst_q", q, 0);
        chk("rst_tc", tc, 0);
        chk("rst_done", done, 0);
        chk("rst_wraps", wraps, 0);
        tick();
        reset = 0;
        model_reset();
    endtask

    initial begin
        tbl[0]  = '{0, 0,  1, 0, 1, 0, 0, 0};
        tbl[1]  = '{1, 7,  1, 0, 7, 0, 0, 0};
        tbl[2]  = '{0, 0,  1, 0, 8, 0, 0, 0};
        tbl[3]  = '{0, 0,  1, 0, 9, 0, 0, 0};
        tbl[4]  = '{0, 0,  1, 0, 0, 1, 0, 1};
        tbl[5]  = '{1, 13, 0, 0, 9, 0, 0, 1};
        tbl[6]  = '{0, 0,  0, 0, 9, 0, 0, 1};
        tbl[7]  = '{0, 0,  1, 1, 9, 1, 1, 1};
        tbl[8]  = '{0, 0,  1, 1, 9, 0, 1, 1};
        tbl[9]  = '{1, 2,  1, 1, 2, 0, 0, 1};
        tbl[10] = '{0, 0,  1, 0, 3, 0, 0, 1};
        tbl[11] = '{1, 15, 0, 0, 9, 0, 0, 1};

        // reset held from time 0 with enable high: tc must stay low
        en = 1;
        #10;
        chk("init_q", q, 0);
        chk("init_tc", tc, 0);
        chk("init_done", done, 0);
        chk("init_wraps", wraps, 0);
        @(posedge clk);
        #1;
        reset = 0;
        model_reset();

        // free-run 12 edges: 1..9,0,1,2 with one wrap
        for (int i = 0; i < 12; i++) apply_check(0, 0, 1, 0, "run12");
        chk("run12_end_q", q, 2);
        chk("run12_end_wraps", wraps, 1);

        // async reset between edges at q=5
        for (int i = 0; i < 3; i++) apply_check(0, 0, 1, 0, "pre_async");
        chk("pre_async_q", q, 5);
        #2;
        reset = 1;
        #1;
        chk("async_q", q, 0);
        chk("async_wraps", wraps, 0);
        chk("async_tc", tc, 0);
        tick();
        chk("async_hold_q", q, 0);
        reset = 0;
        model_reset();
        apply_check(0, 0, 1, 0, "resume");
        chk("resume_q", q, 1);

        // table vectors
        do_reset();
        for (int i = 0; i < 12; i++) begin
            load     = tbl[i].ld;
            load_val = tbl[i].lv[3:0];
            en       = tbl[i].en;
            oneshot  = tbl[i].os;
            #1;
            chk($sformatf("tbl%0d_tc", i), tc, tbl[i].etc);
            tick();
            chk($sformatf("tbl%0d_q", i), q, tbl[i].eq);
            chk($sformatf("tbl%0d_done", i), done, tbl[i].edone);
            chk($sformatf("tbl%0d_wraps", i), wraps, tbl[i].ew);
        end

        // one-shot: reach 9, halt, ignore 20 enables, reload and resume
        do_reset();
        for (int i = 0; i < 9; i++) apply_check(0, 0, 1, 1, "os_run");
        chk("os_at9_q", q, 9);
        chk("os_at9_done", done, 0);
        apply_check(0, 0, 1, 1, "os_halt");
        chk("os_halt_done", done, 1);
        for (int i = 0; i < 20; i++) apply_check(0, 0, 1, 1, "os_held");
        chk("os_held_q", q, 9);
        chk("os_held_tc", tc, 0);
        apply_check(1, 2, 1, 1, "os_load");
        chk("os_load_q", q, 2);
        chk("os_load_done", done, 0);
        apply_check(0, 0, 1, 1, "os_resume");
        chk("os_resume_q", q, 3);

        // random stimulus against the model
        do_reset();
        for (int i = 0; i < 600; i++) begin
            apply_check(($urandom % 8) == 0, int'($urandom % 16),
                        ($urandom % 4) != 0, ($urandom % 2) == 1, "rand");
        end

        // wrap counter saturation
        do_reset();
        for (int i = 0; i < 2600; i++) apply_check(0, 0, 1, 0, "sat");
        chk("sat_wraps", wraps, 255);
        chk("sat_q", q, 0);

        // cascaded pairs, MODULUS 10 and 16
        do_reset();
        cen = 1;
        for (int n = 0; n < 300; n++) begin
            #1;
            if (n < 100) chk("c1_tc", c1_tc, ((n % 10) == 9) ? 1 : 0);
            chk("h1_tc", h1_tc, ((n % 16) == 15) ? 1 : 0);
            tick();
            if (n < 100) begin
                chk("c1_q", c1_q, (n + 1) % 10);
                chk("c2_q", c2_q, ((n + 1) / 10) % 10);
            end
            chk("h1_q", h1_q, (n + 1) % 16);
            chk("h2_q", h2_q, ((n + 1) / 16) % 16);
            if (n == 99) begin
                chk("c_end_c1_q", c1_q, 0);
                chk("c_end_c2_q", c2_q, 0);
                chk("c_end_c2_w", c2_w, 1);
                chk("c_end_c1_w", c1_w, 10);
                cen = 0;
                #2;
                chk("c_hold_c1_tc", c1_tc, 0);
                cen = 1;
            end
        end
        chk("h_end_h2_w", h2_w, 1);
        chk("h_end_h1_w", h1_w, 18);

        $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfail);
        $finish;
    end

endmodule
